// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_pkg
// Brief    : Shared constants and state encoding for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_WIDTH = 32;

  // Iteration counter width; wide enough to count WIDTH iterations.
  localparam int CNT_W = 6;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } div_state_e;

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Restoring radix-2 divider, one quotient bit per cycle, with
//            signed (DIV) and unsigned (DIVU) modes, abort and sign fixup.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             is_signed,
  input  logic             start,
  input  logic             squashn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Conditional two's-complement negate at WIDTH+1 bits, so that the
  // magnitude of the most negative operand stays representable.
  function automatic logic [WIDTH:0] cneg(input logic [WIDTH:0] x, input logic en);
    return en ? (~x + (WIDTH+1)'(1)) : x;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH:0]   dvs_q, dvs_d;       // divisor magnitude
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             signed_q, signed_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic             dvs_zero;
  logic [WIDTH:0]   q_fix, r_fix;
  logic             unused_bits;

  // Operand magnitudes, formed from the live inputs for capture at start.
  assign a_neg = is_signed & opA[WIDTH-1];
  assign b_neg = is_signed & opB[WIDTH-1];
  assign a_mag = cneg({a_neg, opA}, a_neg);
  assign b_mag = cneg({b_neg, opB}, b_neg);

  // One restoring step: shift in the next dividend bit, trial-subtract.
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {1'b0, dvs_q};
  assign q_bit   = ~diff[WIDTH+1];

  // Sign fixup. A zero divisor keeps the all-ones quotient and, because the
  // remainder is negated back, returns the dividend unmodified.
  assign dvs_zero = (dvs_q == '0);
  assign q_fix    = cneg({1'b0, quo_q}, signed_q & (sign_a_q ^ sign_b_q) & ~dvs_zero);
  assign r_fix    = cneg(rem_q, signed_q & sign_a_q);

  // Top bits that are provably zero or discarded after truncation.
  assign unused_bits = ^{rem_q[WIDTH], a_mag[WIDTH], q_fix[WIDTH], r_fix[WIDTH]};

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && squashn) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = a_mag[WIDTH-1:0];
          dvs_d    = b_mag;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          signed_d = is_signed;
        end
      end
      ST_CALC: begin
        if (!squashn) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = q_bit ? diff[WIDTH:0] : shifted;
          quo_d = {quo_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            cnt_d   = '0;
            state_d = ST_FIXUP;
          end
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (squashn) begin
          lo_d   = q_fix[WIDTH-1:0];
          hi_d   = r_fix[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      signed_q <= signed_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Scoreboard bench for div_iter: directed corner cases plus
//            randomized DIV/DIVU traffic against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  localparam int W       = 32;
  localparam int LATENCY = 33;   // posedges from accepting edge to done edge

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] opA, opB;
  logic         is_signed, start, squashn;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .opA       (opA),
    .opB       (opB),
    .is_signed (is_signed),
    .start     (start),
    .squashn   (squashn),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           due;
    string        name;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: truncating division; divide-by-zero gives all ones / dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] q,
                                output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
        check({e.name, "_latency"}, W'(cyc), W'(e.due));
        last_lo = e.lo;
        last_hi = e.hi;
      end
    end
  end

  // Present an operation; optionally keep start high with junk operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit expect_res, input int hold, input bit presynced,
                       input string nm);
    exp_t e;
    if (!presynced) @(negedge clk);
    opA = a; opB = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    #1;
    if (expect_res) begin
      model(a, b, s, e.lo, e.hi);
      e.due  = cyc + LATENCY;
      e.name = nm;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check({nm, "_busy_after_accept"}, {31'b0, busy}, 32'd1);
    if (hold > 0) begin
      opA = ~a; opB = b + 32'd3; is_signed = ~s;
      repeat (hold) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d results pending expected 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string nm);
    issue(a, b, s, 1'b1, 0, 1'b0, nm);
    wait_empty(LATENCY + 10, nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_hi"},   hi, '0);
    check({nm, "_lo"},   lo, '0);
    check({nm, "_busy"}, {31'b0, busy}, 32'd0);
    check({nm, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;

    resetn = 1'b0; squashn = 1'b1; start = 1'b0;
    opA = '0; opB = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) resetn = 1'b1;

    // Directed corner cases.
    run_op(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, "div_7_m2");
    run_op(32'h12345678, 32'd0, 1'b0, "divu_by0");
    run_op(32'h12345678, 32'd0, 1'b1, "div_by0");
    run_op(32'h80000000, 32'd0, 1'b1, "div_min_by0");
    run_op(32'hFFFFFFF9, 32'd0, 1'b1, "div_neg_by0");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, "divu_ovf_ops");
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");

    // Abort in CALC cycle 10; restart on the very next cycle.
    issue(32'd1000, 32'd7, 1'b0, 1'b0, 0, 1'b0, "squashed");
    repeat (9) @(negedge clk);
    squashn = 1'b0;
    @(posedge clk);
    #1;
    check("squash_busy", {31'b0, busy}, 32'd0);
    check("squash_hi_kept", hi, last_hi);
    check("squash_lo_kept", lo, last_lo);
    @(negedge clk);
    squashn = 1'b1;
    issue(32'd9, 32'd3, 1'b0, 1'b1, 0, 1'b1, "after_squash_9_3");
    wait_empty(LATENCY + 10, "after_squash_9_3");

    // Start held high during busy with different operands.
    issue(32'd300, 32'd10, 1'b0, 1'b1, 20, 1'b0, "start_held");
    wait_empty(LATENCY + 10, "start_held");

    // Reset mid-CALC: outputs clear, no done, restart on first edge after release.
    issue(32'd5000, 32'd3, 1'b0, 1'b0, 0, 1'b0, "reset_mid");
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    last_lo = '0;
    last_hi = '0;
    @(negedge clk);
    resetn = 1'b1;
    issue(32'hFFFFFFB3, 32'd5, 1'b1, 1'b1, 0, 1'b1, "after_reset");
    wait_empty(LATENCY + 10, "after_reset");

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      s = 1'(($urandom() % 2));
      a = $urandom();
      case ($urandom() % 4)
        0:       b = $urandom();
        1:       b = $urandom_range(1, 15);
        2:       begin b = $urandom_range(0, 3) - 32'd1; end
        default: begin a = 32'h80000000; b = ($urandom() % 2) ? 32'h0 : 32'hFFFFFFFF; end
      endcase
      run_op(a, b, s, $sformatf("rand%0d", i));
    end

    repeat (40) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_div_iter
`default_nettype wire

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opA  input  WIDTH  dividend, sampled on accepted start.
REQ-005 SHALL have port opB  input  WIDTH  divisor, sampled on accepted start.
REQ-006 SHALL have port is_signed  input  1  1 selects DIV (two's complement), 0 selects DIVU; sampled on accepted start.
REQ-007 SHALL have port start  input  1  request to begin a division.
REQ-008 SHALL have port squashn  input  1  active-low abort of the in-flight division.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking hi/lo valid.
REQ-011 SHALL have port hi  output  WIDTH  remainder.
REQ-012 SHALL have port lo  output  WIDTH  quotient.

Function
REQ-013 SHALL implement a restoring radix-2 divider on magnitudes, one quotient bit per cycle, with states IDLE, CALC and FIXUP.
REQ-014 SHALL accept start only in IDLE with squashn=1; on acceptance it latches the operand magnitudes, operand signs and is_signed, clears the 6-bit iteration counter, and enters CALC.
REQ-015 SHALL, on each CALC cycle, shift {partial remainder, dividend} left by one, subtract the divisor magnitude, keep the difference and set quotient bit 1 if it is non-negative, else restore and set bit 0; the counter increments.
REQ-016 SHALL leave CALC for FIXUP after exactly WIDTH iterations, i.e. the counter wraps at WIDTH-1.
REQ-017 SHALL apply the sign fixup in FIXUP: quotient negated when is_signed and sign(opA)!=sign(opB); remainder negated when is_signed and opA negative. It then registers hi/lo, pulses done for one cycle and returns to IDLE.
REQ-018 SHALL assert done in the 34th cycle after the accepting edge and hold hi/lo stable until the next done.
REQ-019 SHALL assert busy from the cycle after acceptance through the FIXUP cycle, and deassert it in the done cycle.
REQ-020 SHALL ignore start while busy; the in-flight operation is not disturbed.
REQ-021 SHALL abort on squashn=0 in CALC or FIXUP: the next state is IDLE, there is no done pulse, hi/lo are unchanged, and start is accepted from the following cycle.
REQ-022 SHALL, on divisor zero, take full latency and return lo=all ones and hi=opA unmodified, for both signed and unsigned.
REQ-023 SHALL, for signed 0x80000000 / 0xFFFFFFFF, return lo=0x80000000 and hi=0 with no exception signalled.
REQ-024 SHALL perform all magnitude arithmetic at WIDTH+1 bits so that |−2^(WIDTH-1)| is representable.

Reset
REQ-025 SHALL, while resetn=0, force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clear all internal operand registers.
REQ-026 SHALL, on reset asserted mid-operation, discard the operation: no done pulse after release, and start is accepted on the first edge after release.

Structure
REQ-027 SHALL take WIDTH default, the state encoding (IDLE/CALC/FIXUP) and the counter width constant from the shared CPU package.
REQ-028 SHALL contain no sub-module; the conditional two's-complement negate is a local function used for operands and results.

Verification
REQ-029 SHALL cover: DIVU 100/7 → done at cycle 34, lo=14, hi=2, busy low in the done cycle.
REQ-030 SHALL cover: DIV −7/2 (0xFFFFFFF9/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF; and 7/−2 → lo=0xFFFFFFFD, hi=1.
REQ-031 SHALL cover: DIVU and DIV of 0x12345678/0 → lo=0xFFFFFFFF, hi=0x12345678 after 34 cycles.
REQ-032 SHALL cover: DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU of the same operands → lo=0, hi=0x80000000.
REQ-033 SHALL cover: squashn=0 at CALC cycle 10 → no done, hi/lo keep their prior values; start next cycle with 9/3 → lo=3, hi=0 after 34 cycles.
REQ-034 SHALL cover: start held high during busy with other operands → result matches the first operands only; resetn pulsed low mid-CALC → outputs 0, no done.
